// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register. It carries an opaque W-bit payload with a
//   valid/ready handshake. A second (skid) entry absorbs the one beat that can
//   arrive after the downstream side stalls, so in_ready is a plain register
//   output with no combinational path from out_ready.
//   A flush either drops every held entry (FLUSH_MODE=0) or rewrites the held
//   entries as bubbles (FLUSH_MODE=1): the BUBBLE_MASK bits are forced to
//   BUBBLE_VAL, and the valid bits and unmasked payload bits are left alone.
//   flush_cnt counts the entries dropped or bubbled since reset. It saturates
//   at all-ones.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
//   high. A source holds valid and its payload stable until that edge. ready
//   may be high with no valid present. The stage keeps out_data stable while
//   out_valid & ~out_ready. The one exception is a FLUSH_MODE=1 flush, which
//   rewrites the held payload into a bubble.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active low
//   flush      in   1      synchronous flush request
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept (low during reset)
//   in_data    in   W      upstream payload
//   out_valid  out  1      out_data valid
//   out_ready  in   1      downstream accepts
//   out_data   out  W      main register, direct flop output
//   occupancy  out  2      entries held (0..2); also the state observation port
//   flush_cnt  out  CNT_W  saturating count of flushed entries
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int             W           = 32,
  parameter int             FLUSH_MODE  = 0,
  parameter logic [W-1:0]   BUBBLE_MASK = '0,
  parameter logic [W-1:0]   BUBBLE_VAL  = '0,
  parameter logic [W-1:0]   RESET_VAL   = '0,
  parameter int             CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW1 = CNT_W + 1;

  logic             r_main_v;
  logic             r_skid_v;
  logic [W-1:0]     r_main_data;
  logic [W-1:0]     r_skid_data;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_v_nxt;
  logic             w_skid_v_nxt;
  logic [W-1:0]     w_main_d_nxt;
  logic [W-1:0]     w_skid_d_nxt;
  logic [1:0]       w_kill_cnt;
  logic [CW1-1:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_nxt;

  function automatic logic [W-1:0] f_bubble(input logic [W-1:0] d);
    return (d & ~BUBBLE_MASK) | (BUBBLE_VAL & BUBBLE_MASK);
  endfunction

  // The skid entry is full exactly when no more input can be absorbed.
  assign in_ready  = rst & ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
  assign flush_cnt = r_flush_cnt;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_main_v & out_ready;

  always_comb begin
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    w_main_d_nxt = r_main_data;
    w_skid_d_nxt = r_skid_data;
    w_kill_cnt   = 2'd0;
    w_cnt_sum    = '0;
    w_cnt_nxt    = r_flush_cnt;

    // Normal movement. When skid_v=1, in_ready is low, so a freed main
    // register can only refill from the skid entry.
    if (~r_main_v | w_out_xfer) begin
      if (r_skid_v) begin
        w_main_v_nxt = 1'b1;
        w_main_d_nxt = r_skid_data;
        w_skid_v_nxt = 1'b0;
      end else if (w_in_xfer) begin
        w_main_v_nxt = 1'b1;
        w_main_d_nxt = in_data;
      end else begin
        w_main_v_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      w_skid_v_nxt = 1'b1;
      w_skid_d_nxt = in_data;
    end

    // After the movement above, the valid entries are exactly the held
    // entries that did not leave plus any accepted input. Those are the
    // entries a flush kills or bubbles.
    w_kill_cnt = {1'b0, w_main_v_nxt} + {1'b0, w_skid_v_nxt};

    if (flush) begin
      if (FLUSH_MODE == 0) begin
        w_main_v_nxt = 1'b0;
        w_skid_v_nxt = 1'b0;
      end else begin
        if (w_main_v_nxt) w_main_d_nxt = f_bubble(w_main_d_nxt);
        if (w_skid_v_nxt) w_skid_d_nxt = f_bubble(w_skid_d_nxt);
      end
      w_cnt_sum = {1'b0, r_flush_cnt} + CW1'(w_kill_cnt);
      w_cnt_nxt = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_main_data <= RESET_VAL;
      r_skid_data <= RESET_VAL;
      r_flush_cnt <= '0;
    end else begin
      r_main_v    <= w_main_v_nxt;
      r_skid_v    <= w_skid_v_nxt;
      r_main_data <= w_main_d_nxt;
      r_skid_data <= w_skid_d_nxt;
      r_flush_cnt <= w_cnt_nxt;
    end
  end

endmodule
